// File: rtl/arp_recv.sv
// ============================================================================
// Module   : arp_recv
// Brief    : GMII ARP frame receiver. It strips the preamble, captures the
//            Ethernet/ARP header, filters on destination MAC, ethertype and
//            ARP fields, and on acceptance publishes the ARP fields to output
//            registers and a NIOS-II readable register map.
//            Optional FCS check: define ARP_RECV_CRC_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arp_recv #(
  parameter int MAX_FRAME = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_dv,
  input  logic [47:0] i_my_mac,
  input  logic [31:0] i_my_ip,
  input  logic        i_promisc,
  output logic        o_valid,
  output logic [1:0]  o_operation,
  output logic [47:0] o_SHA,
  output logic [31:0] o_SPA,
  output logic [47:0] o_THA,
  output logic [31:0] o_TPA,
  output logic        o_irq,
  input  logic        i_irq_ack,
  input  logic [7:0]  i_rd_addr,
  output logic [31:0] o_rd_data
);

  localparam logic [31:0] MAX_LEN  = MAX_FRAME;
  localparam int          HDR_LEN  = 42;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_BODY     = 3'd2,
    S_DROP     = 3'd3,
    S_COMMIT   = 3'd4
  } state_t;

  state_t      state_q;
  logic        dv_prev_q;
  logic [2:0]  pre_cnt_q;
  logic [10:0] byte_cnt_q;
  logic        drop_flag_q;
  logic        bcast_miss_q, bcast_miss_d;
  logic        mac_miss_q,   mac_miss_d;
  logic        hdr_bad_d;
  logic [7:0]  sh_q [0:HDR_LEN-1];
  logic        valid_q;
  logic [1:0]  oper_q;
  logic [47:0] sha_q, tha_q;
  logic [31:0] spa_q, tpa_q;
  logic        irq_q;
  logic [7:0]  acc_cnt_q, drop_cnt_q;
  logic [31:0] rd_data_q;
  logic        len_ok;
  logic        crc_ok;

  // Frame length is the count of bytes from destination MAC through FCS.
  assign len_ok = (byte_cnt_q >= 11'd64) && ({21'd0, byte_cnt_q} <= MAX_LEN);

`ifdef ARP_RECV_CRC_EN
  logic [31:0] crc_q, crc_d;

  // Reflected CRC-32 advanced by one received byte, LSB first.
  always_comb begin
    crc_d = crc_q ^ {24'h0, i_rx_data};
    for (int b = 0; b < 8; b++) begin
      crc_d = crc_d[0] ? ((crc_d >> 1) ^ 32'hEDB88320) : (crc_d >> 1);
    end
  end

  // CRC register re-seeded during the preamble, accumulates every body byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= 32'hFFFF_FFFF;
    end else if (state_q == S_PREAMBLE) begin
      crc_q <= 32'hFFFF_FFFF;
    end else if (state_q == S_BODY && i_rx_dv) begin
      crc_q <= crc_d;
    end
  end

  // Running the CRC over data plus its own FCS leaves the fixed residue.
  assign crc_ok = (crc_q == 32'hDEBB20E3);
`else
  assign crc_ok = 1'b1;
`endif

  // Per-byte header validation keyed on the byte's position in the frame.
  always_comb begin
    hdr_bad_d    = 1'b0;
    bcast_miss_d = bcast_miss_q;
    mac_miss_d   = mac_miss_q;
    case (byte_cnt_q)
      11'd0: begin
        bcast_miss_d = (i_rx_data != 8'hFF);
        mac_miss_d   = (i_rx_data != i_my_mac[47:40]);
      end
      11'd1: begin
        bcast_miss_d = bcast_miss_q | (i_rx_data != 8'hFF);
        mac_miss_d   = mac_miss_q   | (i_rx_data != i_my_mac[39:32]);
      end
      11'd2: begin
        bcast_miss_d = bcast_miss_q | (i_rx_data != 8'hFF);
        mac_miss_d   = mac_miss_q   | (i_rx_data != i_my_mac[31:24]);
      end
      11'd3: begin
        bcast_miss_d = bcast_miss_q | (i_rx_data != 8'hFF);
        mac_miss_d   = mac_miss_q   | (i_rx_data != i_my_mac[23:16]);
      end
      11'd4: begin
        bcast_miss_d = bcast_miss_q | (i_rx_data != 8'hFF);
        mac_miss_d   = mac_miss_q   | (i_rx_data != i_my_mac[15:8]);
      end
      11'd5: begin
        bcast_miss_d = bcast_miss_q | (i_rx_data != 8'hFF);
        mac_miss_d   = mac_miss_q   | (i_rx_data != i_my_mac[7:0]);
        hdr_bad_d    = bcast_miss_d & mac_miss_d;
      end
      11'd12: hdr_bad_d = (i_rx_data != 8'h08);
      11'd13: hdr_bad_d = (i_rx_data != 8'h06);
      11'd14: hdr_bad_d = (i_rx_data != 8'h00);
      11'd15: hdr_bad_d = (i_rx_data != 8'h01);
      11'd16: hdr_bad_d = (i_rx_data != 8'h08);
      11'd17: hdr_bad_d = (i_rx_data != 8'h00);
      11'd18: hdr_bad_d = (i_rx_data != 8'h06);
      11'd19: hdr_bad_d = (i_rx_data != 8'h04);
      11'd20: hdr_bad_d = (i_rx_data != 8'h00);
      11'd21: hdr_bad_d = !((i_rx_data == 8'h01) || (i_rx_data == 8'h02));
      11'd41: hdr_bad_d = !i_promisc &&
                          ({sh_q[38], sh_q[39], sh_q[40], i_rx_data} != i_my_ip);
      default: hdr_bad_d = 1'b0;
    endcase
  end

  // Receive FSM with shadow capture, output commit, counters and interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      // Treat a still-high dv as already seen so a frame cut by reset is
      // never re-entered from its middle.
      dv_prev_q    <= i_rx_dv;
      pre_cnt_q    <= 3'd0;
      byte_cnt_q   <= 11'd0;
      drop_flag_q  <= 1'b0;
      bcast_miss_q <= 1'b0;
      mac_miss_q   <= 1'b0;
      for (int k = 0; k < HDR_LEN; k++) sh_q[k] <= 8'h00;
      valid_q      <= 1'b0;
      oper_q       <= 2'd0;
      sha_q        <= 48'd0;
      spa_q        <= 32'd0;
      tha_q        <= 48'd0;
      tpa_q        <= 32'd0;
      irq_q        <= 1'b0;
      acc_cnt_q    <= 8'd0;
      drop_cnt_q   <= 8'd0;
    end else begin
      dv_prev_q <= i_rx_dv;
      valid_q   <= 1'b0;
      // Ack first so that a set in COMMIT, assigned later, takes priority.
      if (i_irq_ack) irq_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (i_rx_dv && !dv_prev_q && i_rx_data == 8'h55) begin
            state_q   <= S_PREAMBLE;
            pre_cnt_q <= 3'd1;
          end
        end

        S_PREAMBLE: begin
          if (!i_rx_dv) begin
            state_q    <= S_IDLE;
            drop_cnt_q <= drop_cnt_q + 8'd1;
          end else if (i_rx_data == 8'hD5) begin
            state_q     <= S_BODY;
            byte_cnt_q  <= 11'd0;
            drop_flag_q <= 1'b0;
          end else if (i_rx_data == 8'h55 && pre_cnt_q != 3'd7) begin
            pre_cnt_q <= pre_cnt_q + 3'd1;
          end else begin
            state_q <= S_DROP;
          end
        end

        S_BODY: begin
          if (i_rx_dv) begin
            for (int k = 0; k < HDR_LEN; k++) begin
              if (byte_cnt_q == 11'(k)) sh_q[k] <= i_rx_data;
            end
            if (byte_cnt_q != 11'h7FF) byte_cnt_q <= byte_cnt_q + 11'd1;
            bcast_miss_q <= bcast_miss_d;
            mac_miss_q   <= mac_miss_d;
            if (hdr_bad_d) drop_flag_q <= 1'b1;
          end else if (!drop_flag_q && len_ok && crc_ok) begin
            state_q <= S_COMMIT;
            valid_q <= 1'b1;
            oper_q  <= sh_q[21][1:0];
            sha_q   <= {sh_q[22], sh_q[23], sh_q[24], sh_q[25], sh_q[26], sh_q[27]};
            spa_q   <= {sh_q[28], sh_q[29], sh_q[30], sh_q[31]};
            tha_q   <= {sh_q[32], sh_q[33], sh_q[34], sh_q[35], sh_q[36], sh_q[37]};
            tpa_q   <= {sh_q[38], sh_q[39], sh_q[40], sh_q[41]};
          end else begin
            state_q    <= S_IDLE;
            drop_cnt_q <= drop_cnt_q + 8'd1;
          end
        end

        S_DROP: begin
          if (!i_rx_dv) begin
            state_q    <= S_IDLE;
            drop_cnt_q <= drop_cnt_q + 8'd1;
          end
        end

        S_COMMIT: begin
          irq_q     <= 1'b1;
          acc_cnt_q <= acc_cnt_q + 8'd1;
          // A following frame may already be starting; do not lose its first byte.
          if (i_rx_dv && i_rx_data == 8'h55) begin
            state_q   <= S_PREAMBLE;
            pre_cnt_q <= 3'd1;
          end else begin
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Registered CPU read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= 32'd0;
    end else begin
      case (i_rd_addr)
        8'd0:    rd_data_q <= sha_q[31:0];
        8'd1:    rd_data_q <= {16'h0, sha_q[47:32]};
        8'd2:    rd_data_q <= spa_q;
        8'd3:    rd_data_q <= tha_q[31:0];
        8'd4:    rd_data_q <= {16'h0, tha_q[47:32]};
        8'd5:    rd_data_q <= tpa_q;
        8'd6:    rd_data_q <= {30'h0, oper_q};
        8'd7:    rd_data_q <= {16'h0, drop_cnt_q, acc_cnt_q};
        default: rd_data_q <= 32'd0;
      endcase
    end
  end

  assign o_valid     = valid_q;
  assign o_operation = oper_q;
  assign o_SHA       = sha_q;
  assign o_SPA       = spa_q;
  assign o_THA       = tha_q;
  assign o_TPA       = tpa_q;
  assign o_irq       = irq_q;
  assign o_rd_data   = rd_data_q;

endmodule

`default_nettype wire
